// File: rtl/pe_mac_ws.sv
// Weight-stationary signed MAC processing element with double-buffered weight,
// pipelined multiply, saturating/wrapping accumulate and a sticky overflow flag.
module pe_mac_ws #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned MUL_STAGES = 2,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rest,
  input  logic                         i_weight_load,
  input  logic                         i_weight_swap,
  input  logic signed [DATA_WIDTH-1:0] i_weight_f_top,
  output logic signed [DATA_WIDTH-1:0] o_weight_t_down,
  output logic                         o_weight_load_t_down,
  input  logic                         i_fmap_valid,
  input  logic signed [DATA_WIDTH-1:0] i_fmap_f_left,
  output logic                         o_fmap_valid,
  output logic signed [DATA_WIDTH-1:0] o_fmap_t_right,
  input  logic                         i_psum_valid,
  input  logic signed [ACC_WIDTH-1:0]  i_psum_f_top,
  input  logic                         i_mode,
  output logic                         o_psum_valid,
  output logic signed [ACC_WIDTH-1:0]  o_psum_t_down,
  input  logic                         i_clr_flag,
  output logic                         o_ovf_flag
);

  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] shadow_q, active_q;
  logic                         wload_q;
  logic                         fvld_q;
  logic signed [DATA_WIDTH-1:0] fmap_q;

  logic signed [ACC_WIDTH-1:0]  prod_q [MUL_STAGES];
  logic signed [ACC_WIDTH-1:0]  psum_q [MUL_STAGES];
  logic [MUL_STAGES-1:0]        vld_q;

  logic signed [ACC_WIDTH-1:0]  res_q;
  logic                         res_vld_q;
  logic                         ovf_q;

  logic signed [2*DATA_WIDTH-1:0] mul;
  logic signed [ACC_WIDTH-1:0]    prod_d;
  logic signed [ACC_WIDTH-1:0]    psum_d;
  logic signed [ACC_WIDTH:0]      sum;
  logic                           ovf;
  logic signed [ACC_WIDTH-1:0]    res_d;

  // Issue-stage operands: active_q is the pre-swap value on a swap cycle.
  always_comb begin
    mul    = i_fmap_f_left * active_q;
    prod_d = i_mode ? '0 : ACC_WIDTH'(mul);
    psum_d = i_psum_valid ? i_psum_f_top : '0;
  end

  always_comb begin
    sum = (ACC_WIDTH+1)'(psum_q[MUL_STAGES-1]) + (ACC_WIDTH+1)'(prod_q[MUL_STAGES-1]);
    ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    res_d = sum[ACC_WIDTH-1:0];
    if (ovf && SATURATE) begin
      res_d = sum[ACC_WIDTH] ? AccMin : AccMax;
    end
  end

  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      shadow_q <= '0;
      active_q <= '0;
      wload_q  <= 1'b0;
      fvld_q   <= 1'b0;
      fmap_q   <= '0;
    end else begin
      if (i_weight_load) shadow_q <= i_weight_f_top;
      if (i_weight_swap) active_q <= shadow_q;
      wload_q <= i_weight_load;
      fvld_q  <= i_fmap_valid;
      fmap_q  <= i_fmap_f_left;
    end
  end

  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      for (int i = 0; i < int'(MUL_STAGES); i++) begin
        prod_q[i] <= '0;
        psum_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      prod_q[0] <= prod_d;
      psum_q[0] <= psum_d;
      vld_q[0]  <= i_fmap_valid;
      for (int i = 1; i < int'(MUL_STAGES); i++) begin
        prod_q[i] <= prod_q[i-1];
        psum_q[i] <= psum_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  // Set has priority over clear so a same-cycle overflow is never lost.
  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      res_q     <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      res_vld_q <= vld_q[MUL_STAGES-1];
      if (vld_q[MUL_STAGES-1]) res_q <= res_d;
      if (vld_q[MUL_STAGES-1] && ovf) begin
        ovf_q <= 1'b1;
      end else if (i_clr_flag) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign o_weight_t_down      = shadow_q;
  assign o_weight_load_t_down = wload_q;
  assign o_fmap_valid         = fvld_q;
  assign o_fmap_t_right       = fmap_q;
  assign o_psum_valid         = res_vld_q;
  assign o_psum_t_down        = res_q;
  assign o_ovf_flag           = ovf_q;

endmodule

// File: tb/tb_pe_mac_ws.sv
// Scoreboard bench for pe_mac_ws: a saturating and a wrapping instance share stimulus,
// expected results are queued at issue and checked by per-instance output monitors.
module tb_pe_mac_ws;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst;
  logic w_load, w_swap, f_vld, p_vld, mode, clr;
  logic signed [DW-1:0] w_top, f_left;
  logic signed [AW-1:0] p_top;

  logic signed [DW-1:0] s_wdown, w_wdown, s_fright, w_fright;
  logic                 s_wld, w_wld, s_fvld, w_fvld, s_pvld, w_pvld, s_ovf, w_ovf;
  logic signed [AW-1:0] s_psum, w_psum;

  logic signed [AW-1:0] q_sat[$];
  logic signed [AW-1:0] q_wrap[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_mac_ws #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_STAGES(MS), .SATURATE(1'b1)) u_sat (
    .i_clk(clk), .i_rest(rst),
    .i_weight_load(w_load), .i_weight_swap(w_swap), .i_weight_f_top(w_top),
    .o_weight_t_down(s_wdown), .o_weight_load_t_down(s_wld),
    .i_fmap_valid(f_vld), .i_fmap_f_left(f_left),
    .o_fmap_valid(s_fvld), .o_fmap_t_right(s_fright),
    .i_psum_valid(p_vld), .i_psum_f_top(p_top), .i_mode(mode),
    .o_psum_valid(s_pvld), .o_psum_t_down(s_psum),
    .i_clr_flag(clr), .o_ovf_flag(s_ovf)
  );

  pe_mac_ws #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_STAGES(MS), .SATURATE(1'b0)) u_wrap (
    .i_clk(clk), .i_rest(rst),
    .i_weight_load(w_load), .i_weight_swap(w_swap), .i_weight_f_top(w_top),
    .o_weight_t_down(w_wdown), .o_weight_load_t_down(w_wld),
    .i_fmap_valid(f_vld), .i_fmap_f_left(f_left),
    .o_fmap_valid(w_fvld), .o_fmap_t_right(w_fright),
    .i_psum_valid(p_vld), .i_psum_f_top(p_top), .i_mode(mode),
    .o_psum_valid(w_pvld), .o_psum_t_down(w_psum),
    .i_clr_flag(clr), .o_ovf_flag(w_ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output %0d, nothing queued", name, act);
  endtask

  always @(negedge clk) begin
    if (s_pvld) begin
      if (q_sat.size() == 0) unexpected("sat_psum", s_psum);
      else chk("sat_psum", s_psum, q_sat.pop_front());
    end
    if (w_pvld) begin
      if (q_wrap.size() == 0) unexpected("wrap_psum", w_psum);
      else chk("wrap_psum", w_psum, q_wrap.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_load = 1'b0; w_swap = 1'b0; f_vld = 1'b0; p_vld = 1'b0; mode = 1'b0; clr = 1'b0;
  endtask

  task automatic set_weight(input logic signed [DW-1:0] w);
    w_load = 1'b1; w_top = w;
    step();
    w_load = 1'b0; w_swap = 1'b1;
    step();
    w_swap = 1'b0;
  endtask

  task automatic issue(input logic signed [DW-1:0] f, input logic pv,
                       input logic signed [AW-1:0] p, input logic m,
                       input logic signed [AW-1:0] exp_sat, input logic signed [AW-1:0] exp_wrap,
                       input bit push);
    f_vld = 1'b1; f_left = f; p_vld = pv; p_top = p; mode = m;
    if (push) begin
      q_sat.push_back(exp_sat);
      q_wrap.push_back(exp_wrap);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_sat.size() != 0 || q_wrap.size() != 0) && n < 12) begin
      step();
      n++;
    end
    if (q_sat.size() != 0 || q_wrap.size() != 0) begin
      chk({name, "_drain_pending"}, q_sat.size() + q_wrap.size(), 0);
      q_sat.delete();
      q_wrap.delete();
    end
    step();
  endtask

  initial begin
    idle();
    w_top = '0; f_left = '0; p_top = '0;
    rst = 1'b1;
    #12;
    chk("rst_psum_valid", s_pvld | w_pvld, 0);
    chk("rst_psum", s_psum, 0);
    chk("rst_wdown", s_wdown, 0);
    chk("rst_ovf", s_ovf | w_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Basic MAC: 3 * -5 + 100
    w_load = 1'b1; w_top = 8'sd3;
    step();
    chk("wdown_after_load", s_wdown, 3);
    chk("wload_delayed", s_wld, 1);
    w_load = 1'b0; w_swap = 1'b1;
    step();
    chk("wload_delayed_low", s_wld, 0);
    w_swap = 1'b0;
    issue(-8'sd5, 1'b1, 20'sd100, 1'b0, 20'sd85, 20'sd85, 1'b1);
    step();
    idle();
    chk("fmap_fwd_valid", s_fvld, 1);
    chk("fmap_fwd_data", s_fright, -5);
    step();
    chk("fmap_fwd_valid_low", s_fvld, 0);
    drain("basic");

    // Swap mid-stream: active 2, shadow 4, swap on the second issue
    set_weight(8'sd2);
    w_load = 1'b1; w_top = 8'sd4;
    step();
    w_load = 1'b0;
    issue(8'sd1, 1'b0, 20'sd0, 1'b0, 20'sd2, 20'sd2, 1'b1);
    step();
    issue(8'sd1, 1'b0, 20'sd0, 1'b0, 20'sd2, 20'sd2, 1'b1);
    w_swap = 1'b1;
    step();
    w_swap = 1'b0;
    issue(8'sd1, 1'b0, 20'sd0, 1'b0, 20'sd4, 20'sd4, 1'b1);
    step();
    issue(8'sd1, 1'b0, 20'sd0, 1'b0, 20'sd4, 20'sd4, 1'b1);
    step();
    idle();
    drain("swap");

    // Overflow: 127*127 + 524287 = 540416
    set_weight(8'sd127);
    issue(8'sd127, 1'b1, 20'sd524287, 1'b0, 20'sd524287, -20'sd508160, 1'b1);
    step();
    idle();
    drain("ovf");
    step();
    chk("sat_ovf_sticky", s_ovf, 1);
    chk("wrap_ovf_sticky", w_ovf, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sat_ovf_cleared", s_ovf, 0);
    chk("wrap_ovf_cleared", w_ovf, 0);

    // Bypass, then top row with psum invalid
    set_weight(8'sd7);
    issue(8'sd9, 1'b1, -20'sd42, 1'b1, -20'sd42, -20'sd42, 1'b1);
    step();
    idle();
    drain("bypass");
    chk("bypass_no_ovf", s_ovf | w_ovf, 0);
    set_weight(-8'sd2);
    issue(-8'sd128, 1'b0, 20'sd12345, 1'b0, 20'sd256, 20'sd256, 1'b1);
    step();
    idle();
    // psum without fmap must not issue; the monitor flags any stray output
    p_vld = 1'b1; p_top = 20'sd77;
    step();
    idle();
    drain("toprow");

    // Reset with two operations in flight; nothing queued, so any output is stray
    issue(8'sd3, 1'b1, 20'sd5, 1'b0, 20'sd0, 20'sd0, 1'b0);
    step();
    issue(8'sd4, 1'b1, 20'sd6, 1'b0, 20'sd0, 20'sd0, 1'b0);
    step();
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_psum_valid", s_pvld | w_pvld, 0);
    chk("midrst_psum", s_psum, 0);
    chk("midrst_fmap_valid", s_fvld, 0);
    chk("midrst_wdown", s_wdown, 0);
    chk("midrst_ovf", s_ovf | w_ovf, 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    // Active weight was cleared: product is 0, only the psum passes through
    w_swap = 1'b1;
    issue(8'sd5, 1'b1, 20'sd10, 1'b0, 20'sd10, 20'sd10, 1'b1);
    step();
    idle();
    drain("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
